// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the UART loader port.
// Provides the parser state encoding, the write-target mode, ASCII command
// bytes, the power-on banner and hex/nibble conversion functions.
package uart_loader_pkg;

  typedef enum logic [3:0] {
    IDLE, WRITE, ADDR, COMMIT, RD_REQ, RD_LAT, RD_SEND, RST_HOLD, RST_REL
  } state_t;

  typedef enum logic {MODE_INST, MODE_DATA} mode_t;

  localparam logic [7:0] CH_I  = 8'h69;
  localparam logic [7:0] CH_D  = 8'h64;
  localparam logic [7:0] CH_R  = 8'h72;
  localparam logic [7:0] CH_Q  = 8'h71;
  localparam logic [7:0] CH_P  = 8'h70;
  localparam logic [7:0] CH_AT = 8'h40;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_QM = 8'h3F;

  // "UART OK\r\n"
  localparam int BANNER_LEN = 9;
  localparam logic [7:0] BANNER [BANNER_LEN] = '{
    8'h55, 8'h41, 8'h52, 8'h54, 8'h20, 8'h4F, 8'h4B, 8'h0D, 8'h0A
  };

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ||
           (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Only meaningful when is_hex(c) holds.
  function automatic logic [3:0] hex2nib(input logic [7:0] c);
    if (c <= 8'h39)      return 4'(c - 8'h30);
    else if (c <= 8'h46) return 4'(c - 8'h37);
    else                 return 4'(c - 8'h57);
  endfunction

  // Uppercase ASCII hex digit.
  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide show-ahead FIFO; dout presents the head entry while not empty.
// Ports: clk, rst (sync active-low), push/din, pop/dout, full, empty.
// Pushes while full and pops while empty are ignored; push+pop together is legal.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          wr;
  logic          rd;

  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  // Storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap at the depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader_port.sv
// ASCII command parser turning a UART byte stream into memory writes/reads, CPU halt and reset.
// Ports: rx_data/rx_ready in, tx_data/tx_send/tx_ready out, mem_addr/mem_wdata/iwe/dwe/mem_re/mem_rdata,
// cpuhalt, cpureset, sticky rx_ovf, and dbgdata = registered {mem_addr[15:0], mem_wdata[15:0]}.
module uart_loader_port
  import uart_loader_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int RXQ_DEPTH  = 16,
  parameter int TXQ_DEPTH  = 16,
  parameter int RST_CYCLES = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              iwe,
  output logic              dwe,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpuhalt,
  output logic              cpureset,
  output logic              rx_ovf,
  output logic [31:0]       dbgdata
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = ADDR_W - 2;
  localparam int CW    = $clog2(RST_CYCLES);
  localparam int RCW   = $clog2(NIB + 2);

  state_t            state;
  mode_t             mode;
  logic [IDX_W-1:0]  word_idx;
  logic [CW-1:0]     hold_cnt;
  logic [DATA_W-1:0] rd_sh;
  logic [RCW-1:0]    rd_cnt;
  logic [3:0]        ban_idx;
  logic              ban_done;
  logic              rx_ready_q;
  logic              rx_rise;
  logic              rx_full, rx_empty, rx_pop;
  logic [7:0]        rx_byte;
  logic              tx_full, tx_empty, tx_push, tx_pop, rd_push;
  logic [7:0]        tx_din, tx_dout, echo_ch;
  logic              hex;
  logic [3:0]        nib;

  assign mem_addr = {word_idx, 2'b00};
  assign rx_rise  = rx_ready && !rx_ready_q;
  assign ban_done = (ban_idx == 4'(BANNER_LEN));
  assign tx_pop   = tx_ready && !tx_send && !tx_empty;
  assign hex      = is_hex(rx_byte);
  assign nib      = hex2nib(rx_byte);

  byte_fifo #(.DEPTH(RXQ_DEPTH)) u_rxq (
    .clk(clk), .rst(rst), .push(rx_rise), .din(rx_data),
    .pop(rx_pop), .dout(rx_byte), .full(rx_full), .empty(rx_empty)
  );

  byte_fifo #(.DEPTH(TXQ_DEPTH)) u_txq (
    .clk(clk), .rst(rst), .push(tx_push), .din(tx_din),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  // TX FIFO writers are mutually exclusive by state: banner right after reset,
  // hex read-back in RD_SEND, echo in IDLE. An IDLE byte is only consumed once
  // its echo has room, so echoes are never lost.
  always_comb begin
    echo_ch = CH_QM;
    if (rx_byte == CH_I || rx_byte == CH_D || rx_byte == CH_R) echo_ch = rx_byte;
    rd_push = ban_done && (state == RD_SEND) && !tx_full;
    rx_pop  = 1'b0;
    tx_push = 1'b0;
    tx_din  = 8'h00;
    if (!ban_done) begin
      tx_push = 1'b1;
      tx_din  = BANNER[ban_idx];
    end else if (rd_push) begin
      tx_push = 1'b1;
      if (rd_cnt < RCW'(NIB))       tx_din = nib2hex(rd_sh[DATA_W-1 -: 4]);
      else if (rd_cnt == RCW'(NIB)) tx_din = CH_CR;
      else                          tx_din = CH_LF;
    end else if (state == IDLE && !rx_empty && !tx_full) begin
      rx_pop  = 1'b1;
      tx_push = 1'b1;
      tx_din  = echo_ch;
    end
    if ((state == WRITE || state == ADDR) && !rx_empty) rx_pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mode       <= MODE_INST;
      word_idx   <= '0;
      mem_wdata  <= '0;
      hold_cnt   <= '0;
      rd_sh      <= '0;
      rd_cnt     <= '0;
      ban_idx    <= '0;
      rx_ready_q <= 1'b0;
      rx_ovf     <= 1'b0;
      tx_data    <= 8'h00;
      tx_send    <= 1'b0;
      iwe        <= 1'b0;
      dwe        <= 1'b0;
      mem_re     <= 1'b0;
      cpuhalt    <= 1'b0;
      cpureset   <= 1'b0;
      dbgdata    <= '0;
    end else begin
      rx_ready_q <= rx_ready;
      if (rx_rise && rx_full) rx_ovf <= 1'b1;
      if (!ban_done) ban_idx <= ban_idx + 1'b1;

      // tx_send stays up until the transmitter drops tx_ready.
      if (tx_pop) begin
        tx_data <= tx_dout;
        tx_send <= 1'b1;
      end else if (tx_send && !tx_ready) begin
        tx_send <= 1'b0;
      end

      iwe     <= 1'b0;
      dwe     <= 1'b0;
      mem_re  <= 1'b0;
      dbgdata <= {mem_addr[15:0], mem_wdata[15:0]};

      case (state)
        IDLE: if (rx_pop) begin
          if (rx_byte == CH_I || rx_byte == CH_D) begin
            mode      <= (rx_byte == CH_I) ? MODE_INST : MODE_DATA;
            cpuhalt   <= 1'b1;
            word_idx  <= '0;
            mem_wdata <= '0;
            state     <= WRITE;
          end else if (rx_byte == CH_R) begin
            cpureset <= 1'b1;
            hold_cnt <= '0;
            state    <= RST_HOLD;
          end
        end
        WRITE: if (rx_pop) begin
          if (hex) begin
            mem_wdata <= DATA_W'({mem_wdata, nib});
          end else if (rx_byte == CH_AT) begin
            word_idx  <= '0;
            mem_wdata <= '0;
            state     <= ADDR;
          end else if (rx_byte == CH_LF) begin
            // Strobe is raised on entry so it is high for the COMMIT cycle only.
            iwe   <= (mode == MODE_INST);
            dwe   <= (mode == MODE_DATA);
            state <= COMMIT;
          end else if (rx_byte == CH_P) begin
            mem_re <= 1'b1;
            state  <= RD_REQ;
          end else if (rx_byte == CH_Q) begin
            cpuhalt  <= 1'b0;
            cpureset <= 1'b1;
            hold_cnt <= '0;
            state    <= RST_HOLD;
          end
        end
        ADDR: if (rx_pop) begin
          if (hex) word_idx <= IDX_W'({word_idx, nib});
          else if (rx_byte == CH_LF) state <= WRITE;
        end
        COMMIT: begin
          word_idx  <= word_idx + 1'b1;
          mem_wdata <= '0;
          state     <= WRITE;
        end
        RD_REQ: state <= RD_LAT;
        RD_LAT: begin
          rd_sh  <= mem_rdata;
          rd_cnt <= '0;
          state  <= RD_SEND;
        end
        RD_SEND: if (rd_push) begin
          if (rd_cnt < RCW'(NIB)) rd_sh <= rd_sh << 4;
          if (rd_cnt == RCW'(NIB + 1)) begin
            word_idx <= word_idx + 1'b1;
            state    <= WRITE;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        // The entry cycle and RST_REL each hold cpureset for one cycle, so the
        // counter stops two short to give RST_CYCLES high cycles in total.
        RST_HOLD: begin
          if (hold_cnt == CW'(RST_CYCLES - 2)) state <= RST_REL;
          else hold_cnt <= hold_cnt + 1'b1;
        end
        RST_REL: begin
          cpureset <= 1'b0;
          cpuhalt  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
